// File: rtl/uart_debug_pkg.sv
// rtl/uart_debug_pkg.sv - register map, STATUS bit positions and FSM state types for uart_debug_ctrl
package uart_debug_pkg;

  localparam logic [1:0] REG_DATA    = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_DIVIDER = 2'd2;
  localparam logic [1:0] REG_IRQ_EN  = 2'd3;

  localparam int ST_TX_BUSY   = 0;
  localparam int ST_TX_FULL   = 1;
  localparam int ST_RX_VALID  = 2;
  localparam int ST_RX_OVR    = 3;
  localparam int ST_RX_FERR   = 4;
  localparam int ST_TX_OVF    = 5;
  localparam int ST_LEVEL_LSB = 8;

  typedef enum logic [1:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with wrap-bit pointers, full/empty and level outputs
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A push while full is dropped even when a pop frees a slot in the same cycle.
  assign level    = wr_ptr - rd_ptr;
  assign full     = (level == FULL_LEVEL);
  assign empty    = (wr_ptr == rd_ptr);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/uart_debug_ctrl.sv
// rtl/uart_debug_ctrl.sv - debug UART with TX FIFO, programmable divider, RX holding register and IRQ
module uart_debug_ctrl
  import uart_debug_pkg::*;
#(
  parameter int CLK_HZ     = 25_000_000,
  parameter int BIT_RATE   = 1_000_000,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_WIDTH  = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  addr,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic        data_read_complete,
  output logic [31:0] data_out,
  input  logic        uart_rxd,
  output logic        uart_txd,
  output logic        tx_busy,
  output logic        interrupt
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [DIV_WIDTH-1:0] DIV_RESET = DIV_WIDTH'(CLK_HZ / BIT_RATE - 1);
  localparam logic [DIV_WIDTH-1:0] DIV_MIN   = DIV_WIDTH'(3);

  logic [DIV_WIDTH-1:0] div_q;
  logic [1:0]           irq_en;
  logic                 tx_ovf;
  logic                 rx_ovr;
  logic                 rx_ferr;
  logic                 rx_valid;
  logic [7:0]           rx_byte;

  logic wr_en, wr_data, wr_status, wr_div, wr_irq, rd_pop;
  logic [DIV_WIDTH-1:0] wr_div_val;
  logic unused_data_in;

  assign wr_en      = (data_write_n != 2'b11);
  assign wr_data    = wr_en && (addr == REG_DATA);
  assign wr_status  = wr_en && (addr == REG_STATUS);
  assign wr_div     = wr_en && (addr == REG_DIVIDER);
  assign wr_irq     = wr_en && (addr == REG_IRQ_EN);
  assign rd_pop     = data_read_complete && (addr == REG_DATA);
  assign wr_div_val = (data_in[DIV_WIDTH-1:0] < DIV_MIN) ? DIV_MIN : data_in[DIV_WIDTH-1:0];
  assign unused_data_in = &{1'b0, data_in[31:DIV_WIDTH]};

  logic             fifo_full, fifo_empty, tx_pop;
  logic [7:0]       fifo_dout;
  logic [LVL_W-1:0] fifo_level;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (wr_data),
    .push_data (data_in[7:0]),
    .pop       (tx_pop),
    .pop_data  (fifo_dout),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  tx_state_t            tx_state, tx_state_n;
  logic [DIV_WIDTH-1:0] tx_cnt, tx_cnt_n;
  logic [2:0]           tx_idx, tx_idx_n;
  logic [7:0]           tx_shift, tx_shift_n;
  logic                 txd_q, txd_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
      txd_q    <= 1'b1;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_idx   <= tx_idx_n;
      tx_shift <= tx_shift_n;
      txd_q    <= txd_n;
    end
  end

  // The bit counter reloads from div_q at every bit boundary, so a divider
  // change never stretches or shortens a bit already on the wire.
  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_idx_n   = tx_idx;
    tx_shift_n = tx_shift;
    txd_n      = txd_q;
    tx_pop     = 1'b0;
    case (tx_state)
      TX_IDLE: tx_pop = !fifo_empty;
      TX_START: begin
        if (tx_cnt == '0) begin
          tx_state_n = TX_DATA;
          tx_cnt_n   = div_q;
          tx_idx_n   = 3'd0;
          txd_n      = tx_shift[0];
        end else begin
          tx_cnt_n = tx_cnt - 1'b1;
        end
      end
      TX_DATA: begin
        if (tx_cnt == '0) begin
          tx_cnt_n = div_q;
          if (tx_idx == 3'd7) begin
            tx_state_n = TX_STOP;
            txd_n      = 1'b1;
          end else begin
            tx_idx_n = tx_idx + 3'd1;
            txd_n    = tx_shift[tx_idx + 3'd1];
          end
        end else begin
          tx_cnt_n = tx_cnt - 1'b1;
        end
      end
      TX_STOP: begin
        if (tx_cnt == '0) begin
          if (fifo_empty) tx_state_n = TX_IDLE;
          else            tx_pop     = 1'b1;
        end else begin
          tx_cnt_n = tx_cnt - 1'b1;
        end
      end
      default: tx_state_n = TX_IDLE;
    endcase
    if (tx_pop) begin
      tx_state_n = TX_START;
      tx_cnt_n   = div_q;
      tx_shift_n = fifo_dout;
      txd_n      = 1'b0;
    end
  end

  assign uart_txd = txd_q;
  assign tx_busy  = !fifo_empty || (tx_state != TX_IDLE);

  logic                 rx_s1, rx_s2, rx_s3;
  rx_state_t            rx_state, rx_state_n;
  logic [DIV_WIDTH-1:0] rx_cnt, rx_cnt_n;
  logic [2:0]           rx_idx, rx_idx_n;
  logic [7:0]           rx_shift, rx_shift_n;
  logic                 rx_stop_ok, rx_stop_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_s3    <= 1'b1;
      rx_state <= RX_IDLE;
      rx_cnt   <= '0;
      rx_idx   <= '0;
      rx_shift <= '0;
    end else begin
      rx_s1    <= uart_rxd;
      rx_s2    <= rx_s1;
      rx_s3    <= rx_s2;
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_idx   <= rx_idx_n;
      rx_shift <= rx_shift_n;
    end
  end

  // First wait is half a bit so every later sample lands mid-bit.
  always_comb begin
    rx_state_n  = rx_state;
    rx_cnt_n    = rx_cnt;
    rx_idx_n    = rx_idx;
    rx_shift_n  = rx_shift;
    rx_stop_ok  = 1'b0;
    rx_stop_bad = 1'b0;
    case (rx_state)
      RX_IDLE: begin
        if (rx_s3 && !rx_s2) begin
          rx_state_n = RX_START;
          rx_cnt_n   = div_q >> 1;
        end
      end
      RX_START: begin
        if (rx_cnt == '0) begin
          rx_cnt_n   = div_q;
          rx_idx_n   = 3'd0;
          rx_state_n = rx_s2 ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_n = rx_cnt - 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt == '0) begin
          rx_cnt_n           = div_q;
          rx_shift_n[rx_idx] = rx_s2;
          if (rx_idx == 3'd7) rx_state_n = RX_STOP;
          else                rx_idx_n   = rx_idx + 3'd1;
        end else begin
          rx_cnt_n = rx_cnt - 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt == '0) begin
          rx_state_n  = RX_IDLE;
          rx_stop_ok  = rx_s2;
          rx_stop_bad = !rx_s2;
        end else begin
          rx_cnt_n = rx_cnt - 1'b1;
        end
      end
      default: rx_state_n = RX_IDLE;
    endcase
  end

  logic rx_load, rx_ovr_set;

  // A byte completing in the same cycle the host consumes the old one is a load, not an overrun.
  assign rx_load    = rx_stop_ok && (!rx_valid || rd_pop);
  assign rx_ovr_set = rx_stop_ok && rx_valid && !rd_pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q    <= DIV_RESET;
      irq_en   <= '0;
      tx_ovf   <= 1'b0;
      rx_ovr   <= 1'b0;
      rx_ferr  <= 1'b0;
      rx_valid <= 1'b0;
      rx_byte  <= '0;
    end else begin
      if (wr_div) div_q  <= wr_div_val;
      if (wr_irq) irq_en <= data_in[1:0];

      if (wr_data && fifo_full)                    tx_ovf <= 1'b1;
      else if (wr_status && data_in[ST_TX_OVF])    tx_ovf <= 1'b0;
      if (rx_ovr_set)                              rx_ovr <= 1'b1;
      else if (wr_status && data_in[ST_RX_OVR])    rx_ovr <= 1'b0;
      if (rx_stop_bad)                             rx_ferr <= 1'b1;
      else if (wr_status && data_in[ST_RX_FERR])   rx_ferr <= 1'b0;

      if (rx_load) begin
        rx_valid <= 1'b1;
        rx_byte  <= rx_shift;
      end else if (rd_pop) begin
        rx_valid <= 1'b0;
      end
    end
  end

  logic [31:0] status_word;

  always_comb begin
    status_word                       = '0;
    status_word[ST_TX_BUSY]           = tx_busy;
    status_word[ST_TX_FULL]           = fifo_full;
    status_word[ST_RX_VALID]          = rx_valid;
    status_word[ST_RX_OVR]            = rx_ovr;
    status_word[ST_RX_FERR]           = rx_ferr;
    status_word[ST_TX_OVF]            = tx_ovf;
    status_word[ST_LEVEL_LSB +: 8]    = 8'(fifo_level);
  end

  always_comb begin
    data_out = '0;
    case (addr)
      REG_DATA:    data_out = rx_valid ? {24'h0, rx_byte} : 32'hFFFF_FFFF;
      REG_STATUS:  data_out = status_word;
      REG_DIVIDER: data_out = 32'(div_q);
      REG_IRQ_EN:  data_out = {30'h0, irq_en};
      default:     data_out = '0;
    endcase
  end

  assign interrupt = (irq_en[0] && rx_valid) || (irq_en[1] && !tx_busy);

endmodule

// File: tb/tb_uart_debug_ctrl.sv
// tb/tb_uart_debug_ctrl.sv - directed self-checking bench for uart_debug_ctrl
module tb_uart_debug_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  addr = 2'd0;
  logic [31:0] data_in = 32'h0;
  logic [1:0]  data_write_n = 2'b11;
  logic        data_read_complete = 1'b0;
  logic [31:0] data_out;
  logic        uart_rxd = 1'b1;
  logic        uart_txd;
  logic        tx_busy;
  logic        interrupt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  uart_debug_ctrl #(
    .CLK_HZ     (25_000_000),
    .BIT_RATE   (1_000_000),
    .FIFO_DEPTH (8),
    .DIV_WIDTH  (12)
  ) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .addr               (addr),
    .data_in            (data_in),
    .data_write_n       (data_write_n),
    .data_read_complete (data_read_complete),
    .data_out           (data_out),
    .uart_rxd           (uart_rxd),
    .uart_txd           (uart_txd),
    .tx_busy            (tx_busy),
    .interrupt          (interrupt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_reg(input string tag, input logic [1:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    chk(tag, data_out, exp);
  endtask

  // Called at a negedge; the following posedge performs the write.
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    addr         = a;
    data_in      = d;
    data_write_n = 2'b00;
    @(negedge clk);
    data_write_n = 2'b11;
    data_in      = 32'h0;
  endtask

  // Entered just after the push edge (edge 0); checks uart_txd after each edge of the frame.
  task automatic tx_frame(input logic [7:0] b, input int div, input string tag);
    int bl;
    bl = div + 1;
    for (int k = 1; k <= 10 * bl; k++) begin
      logic e;
      @(negedge clk);
      if (k <= bl)          e = 1'b0;
      else if (k > 9 * bl)  e = 1'b1;
      else                  e = b[(k - bl - 1) / bl];
      chk1(tag, uart_txd, e);
    end
    @(negedge clk);
    chk1({tag, "_busy_fall"}, tx_busy, 1'b0);
  endtask

  // Drives one frame on uart_rxd; samples rx_valid after edges probe-1 and probe.
  task automatic rx_frame(input logic [7:0] b, input int bl, input logic stop_bit, input int probe,
                          output logic v_before, output logic v_at);
    v_before = 1'b0;
    v_at     = 1'b0;
    addr     = 2'd1;
    for (int k = 0; k < 10 * bl; k++) begin
      if (k < bl)           uart_rxd = 1'b0;
      else if (k >= 9 * bl) uart_rxd = stop_bit;
      else                  uart_rxd = b[(k - bl) / bl];
      @(negedge clk);
      if (k == probe - 1) v_before = data_out[2];
      if (k == probe)     v_at     = data_out[2];
    end
    uart_rxd = 1'b1;
  endtask

  initial begin
    logic vb, va;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk1("rst_txd", uart_txd, 1'b1);
    chk1("rst_busy", tx_busy, 1'b0);
    chk1("rst_irq", interrupt, 1'b0);
    chk_reg("rst_status", 2'd1, 32'h0000_0000);
    chk_reg("rst_divider", 2'd2, 32'd24);
    chk_reg("rst_irq_en", 2'd3, 32'h0);
    chk_reg("rst_data", 2'd0, 32'hFFFF_FFFF);

    wr(2'd0, 32'h55);
    chk1("tx55_busy_rise", tx_busy, 1'b1);
    chk1("tx55_txd_edge0", uart_txd, 1'b1);
    tx_frame(8'h55, 24, "tx55");

    for (int i = 0; i < 9; i++) wr(2'd0, i);
    chk_reg("fifo_full", 2'd1, 32'h0000_0803);
    wr(2'd0, 32'h09);
    chk_reg("tx_ovf_set", 2'd1, 32'h0000_0823);
    repeat (241) @(negedge clk);
    chk1("b2b_last_stop", uart_txd, 1'b1);
    chk_reg("b2b_level8", 2'd1, 32'h0000_0823);
    @(negedge clk);
    chk1("b2b_no_gap", uart_txd, 1'b0);
    chk_reg("b2b_level7", 2'd1, 32'h0000_0721);
    wr(2'd1, 32'h20);
    chk_reg("tx_ovf_clear", 2'd1, 32'h0000_0701);
    repeat (1998) @(negedge clk);
    chk1("b2b_busy_last", tx_busy, 1'b1);
    @(negedge clk);
    chk1("b2b_busy_fall", tx_busy, 1'b0);
    chk_reg("b2b_status_idle", 2'd1, 32'h0);

    wr(2'd3, 32'h2);
    chk1("irq_tx_idle", interrupt, 1'b1);
    wr(2'd3, 32'h0);
    chk1("irq_off", interrupt, 1'b0);

    wr(2'd2, 32'd99);
    chk_reg("div_99", 2'd2, 32'd99);
    wr(2'd0, 32'hA3);
    tx_frame(8'hA3, 99, "txA3");
    wr(2'd2, 32'd1);
    chk_reg("div_clamp", 2'd2, 32'd3);
    wr(2'd2, 32'd24);
    chk_reg("div_24", 2'd2, 32'd24);

    wr(2'd3, 32'h1);
    rx_frame(8'h3C, 25, 1'b1, 240, vb, va);
    chk1("rx_valid_early", vb, 1'b0);
    chk1("rx_valid_rise", va, 1'b1);
    chk_reg("rx_status", 2'd1, 32'h0000_0004);
    chk_reg("rx_data", 2'd0, 32'h0000_003C);
    chk1("rx_irq", interrupt, 1'b1);
    addr = 2'd0;
    data_read_complete = 1'b1;
    @(negedge clk);
    data_read_complete = 1'b0;
    chk_reg("rx_pop_status", 2'd1, 32'h0);
    chk1("rx_pop_irq", interrupt, 1'b0);
    chk_reg("rx_pop_data", 2'd0, 32'hFFFF_FFFF);

    uart_rxd = 1'b0;
    repeat (10) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (300) @(negedge clk);
    chk_reg("rx_glitch", 2'd1, 32'h0);

    rx_frame(8'hA5, 25, 1'b0, 240, vb, va);
    repeat (5) @(negedge clk);
    chk_reg("rx_ferr", 2'd1, 32'h0000_0010);
    wr(2'd1, 32'h10);
    chk_reg("rx_ferr_clear", 2'd1, 32'h0);

    rx_frame(8'h11, 25, 1'b1, 240, vb, va);
    repeat (5) @(negedge clk);
    rx_frame(8'h22, 25, 1'b1, 240, vb, va);
    repeat (5) @(negedge clk);
    chk_reg("rx_ovr", 2'd1, 32'h0000_000C);
    chk_reg("rx_ovr_data", 2'd0, 32'h0000_0011);
    wr(2'd1, 32'h08);
    chk_reg("rx_ovr_clear", 2'd1, 32'h0000_0004);

    wr(2'd2, 32'd30);
    wr(2'd0, 32'h52);
    wr(2'd0, 32'h77);
    repeat (139) @(negedge clk);
    chk1("mid_bit3", uart_txd, 1'b0);
    chk_reg("mid_status", 2'd1, 32'h0000_0105);
    #2;
    rst_n = 1'b0;
    #1;
    chk1("arst_txd", uart_txd, 1'b1);
    chk1("arst_busy", tx_busy, 1'b0);
    @(negedge clk);
    chk_reg("arst_status", 2'd1, 32'h0);
    chk_reg("arst_divider", 2'd2, 32'd24);
    rst_n = 1'b1;
    @(negedge clk);
    chk1("post_rst_txd", uart_txd, 1'b1);
    chk1("post_rst_irq", interrupt, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
